// File: rtl/qspi_mon_pkg.sv
// rtl/qspi_mon_pkg.sv - shared types, command constants and phase decode for the QSPI bus monitor
package qspi_mon_pkg;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, SKIP} state_t;

    typedef enum logic [1:0] {LANE_1 = 2'd0, LANE_2 = 2'd1, LANE_4 = 2'd2} lane_t;

    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_DUAL_IO   = 8'hBB;
    localparam logic [7:0] CMD_QUAD_IO   = 8'hEB;

    typedef struct packed {
        logic       known;
        lane_t      lanes;
        logic [7:0] addr_cycles;
        logic [7:0] dummy_cycles;
    } phase_cfg_t;

    // Address cycles scale with the address width; the quad dummy count includes the mode cycles.
    function automatic phase_cfg_t phase_cfg(input logic [7:0] cmd_byte, input int addr_width);
        phase_cfg_t c;
        c.known        = 1'b1;
        c.lanes        = LANE_1;
        c.addr_cycles  = 8'(addr_width);
        c.dummy_cycles = 8'd8;
        case (cmd_byte)
            CMD_FAST_READ: begin
                c.lanes        = LANE_1;
                c.addr_cycles  = 8'(addr_width);
                c.dummy_cycles = 8'd8;
            end
            CMD_DUAL_IO: begin
                c.lanes        = LANE_2;
                c.addr_cycles  = 8'(addr_width / 2);
                c.dummy_cycles = 8'd4;
            end
            CMD_QUAD_IO: begin
                c.lanes        = LANE_4;
                c.addr_cycles  = 8'(addr_width / 4);
                c.dummy_cycles = 8'd6;
            end
            default: begin
                c.known        = 1'b0;
                c.addr_cycles  = 8'd0;
                c.dummy_cycles = 8'd0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/qspi_bus_monitor_edge_sync.sv
// rtl/qspi_bus_monitor_edge_sync.sv - pin synchronizer with registered sample-edge and cs-edge pulses
module qspi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       sclk,
    input  logic       cs,
    input  logic [3:0] sio,
    output logic       sample_edge,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic [3:0] sample_sio
);

    logic [SYNC_STAGES-1:0]      sclk_sync;
    logic [SYNC_STAGES-1:0]      cs_sync;
    logic [SYNC_STAGES-1:0][3:0] sio_sync;
    logic                        sclk_d;
    logic                        cs_d;
    logic [3:0]                  sio_d;
    logic                        sclk_rise;
    logic                        sclk_fall;

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;

    // Chains reset low so a cs held low across reset never looks like a fresh frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync   <= '0;
            cs_sync     <= '0;
            sio_sync    <= '0;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b0;
            sio_d       <= 4'h0;
            sample_edge <= 1'b0;
            cs_fall     <= 1'b0;
            cs_rise     <= 1'b0;
            sample_sio  <= 4'h0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
            sio_sync    <= {sio_sync[SYNC_STAGES-2:0], sio};
            sclk_d      <= sclk_sync[SYNC_STAGES-1];
            cs_d        <= cs_sync[SYNC_STAGES-1];
            sio_d       <= sio_sync[SYNC_STAGES-1];
            sample_edge <= (cpol == cpha) ? sclk_rise : sclk_fall;
            sample_sio  <= sio_d;
            cs_fall     <= ~cs_sync[SYNC_STAGES-1] & cs_d;
            cs_rise     <= cs_sync[SYNC_STAGES-1] & ~cs_d;
        end
    end

endmodule

// File: rtl/qspi_bus_monitor.sv
// rtl/qspi_bus_monitor.sv - passive QSPI read-frame decoder; QSPI_MON_COMPARE_EN adds the expected-data comparator
module qspi_bus_monitor
    import qspi_mon_pkg::*;
#(
    parameter int CMD_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 24,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef QSPI_MON_COMPARE_EN
    input  logic [7:0]            exp_data,
    output logic                  cmp_err,
    output logic [CNT_WIDTH-1:0]  mism_count,
`endif
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic [3:0]            sio,
    output logic                  cmd_valid,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic                  addr_valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  data_valid,
    output logic [7:0]            data,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic                  err_cmd,
    output logic                  err_trunc
);

    logic                  sample_edge;
    logic                  cs_fall;
    logic                  cs_rise;
    logic [3:0]            sample_sio;

    state_t                state;
    lane_t                 lanes_q;
    logic [7:0]            addr_cyc_q;
    logic [7:0]            dummy_cyc_q;
    logic [7:0]            phase_cnt;
    logic [3:0]            data_bits;
    logic [CMD_WIDTH-2:0]  cmd_sr;
    logic [ADDR_WIDTH-2:0] addr_sr;
    logic [6:0]            data_sr;

    logic [CMD_WIDTH-1:0]  cmd_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [7:0]            data_next;
    logic [3:0]            data_bits_next;
    phase_cfg_t            dec_cfg;

    qspi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk        (clk),
        .reset      (reset),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk       (sclk),
        .cs         (cs),
        .sio        (sio),
        .sample_edge(sample_edge),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise),
        .sample_sio (sample_sio)
    );

    assign cmd_next = {cmd_sr, sample_sio[0]};
    assign dec_cfg  = phase_cfg(cmd_next[7:0], ADDR_WIDTH);

    // Single-lane data arrives on sio[1]; address and command always use sio[0] in that mode.
    always_comb begin
        addr_next      = {addr_sr, sample_sio[0]};
        data_next      = {data_sr, sample_sio[1]};
        data_bits_next = data_bits + 4'd1;
        case (lanes_q)
            LANE_2: begin
                addr_next      = {addr_sr[ADDR_WIDTH-3:0], sample_sio[1:0]};
                data_next      = {data_sr[5:0], sample_sio[1:0]};
                data_bits_next = data_bits + 4'd2;
            end
            LANE_4: begin
                addr_next      = {addr_sr[ADDR_WIDTH-5:0], sample_sio};
                data_next      = {data_sr[3:0], sample_sio};
                data_bits_next = data_bits + 4'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lanes_q     <= LANE_1;
            addr_cyc_q  <= 8'd0;
            dummy_cyc_q <= 8'd0;
            phase_cnt   <= 8'd0;
            data_bits   <= 4'd0;
            cmd_sr      <= '0;
            addr_sr     <= '0;
            data_sr     <= 7'd0;
            cmd_valid   <= 1'b0;
            cmd         <= '0;
            addr_valid  <= 1'b0;
            addr        <= '0;
            data_valid  <= 1'b0;
            data        <= 8'h00;
            frame_done  <= 1'b0;
            byte_count  <= '0;
            err_cmd     <= 1'b0;
            err_trunc   <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            addr_valid <= 1'b0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            // A cs rise takes priority over a coincident sample edge, which is dropped.
            if (cs_rise) begin
                if (state != IDLE) begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    if (state == CMD || state == ADDR || state == DUMMY ||
                        (state == DATA && (data_bits != 4'd0 || byte_count == '0))) begin
                        err_trunc <= 1'b1;
                    end
                end
            end else if (cs_fall && state == IDLE) begin
                state      <= CMD;
                phase_cnt  <= 8'd0;
                data_bits  <= 4'd0;
                byte_count <= '0;
            end else if (sample_edge) begin
                case (state)
                    CMD: begin
                        cmd_sr    <= cmd_next[CMD_WIDTH-2:0];
                        phase_cnt <= phase_cnt + 8'd1;
                        if (phase_cnt == 8'(CMD_WIDTH - 1)) begin
                            cmd         <= cmd_next;
                            cmd_valid   <= 1'b1;
                            phase_cnt   <= 8'd0;
                            lanes_q     <= dec_cfg.lanes;
                            addr_cyc_q  <= dec_cfg.addr_cycles;
                            dummy_cyc_q <= dec_cfg.dummy_cycles;
                            if (dec_cfg.known) begin
                                state <= ADDR;
                            end else begin
                                err_cmd <= 1'b1;
                                state   <= SKIP;
                            end
                        end
                    end
                    ADDR: begin
                        addr_sr   <= addr_next[ADDR_WIDTH-2:0];
                        phase_cnt <= phase_cnt + 8'd1;
                        if (phase_cnt == addr_cyc_q - 8'd1) begin
                            addr       <= addr_next;
                            addr_valid <= 1'b1;
                            phase_cnt  <= 8'd0;
                            state      <= (dummy_cyc_q == 8'd0) ? DATA : DUMMY;
                        end
                    end
                    DUMMY: begin
                        phase_cnt <= phase_cnt + 8'd1;
                        if (phase_cnt == dummy_cyc_q - 8'd1) begin
                            phase_cnt <= 8'd0;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (data_bits_next == 4'd8) begin
                            data       <= data_next;
                            data_valid <= 1'b1;
                            data_bits  <= 4'd0;
                            if (byte_count != '1) begin
                                byte_count <= byte_count + 1'b1;
                            end
                        end else begin
                            data_sr   <= data_next[6:0];
                            data_bits <= data_bits_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef QSPI_MON_COMPARE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_err    <= 1'b0;
            mism_count <= '0;
        end else begin
            cmp_err <= 1'b0;
            if (data_valid && data != exp_data) begin
                cmp_err <= 1'b1;
                if (mism_count != '1) begin
                    mism_count <= mism_count + 1'b1;
                end
            end
        end
    end
`endif

endmodule
